// File: rtl/fwft_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module : fwft_fifo_mc
// Brief  : NCH independent first-word-fall-through ring-buffer FIFOs with
//          per-channel flush, almost-full, occupancy count and optional
//          sticky error flags (enabled by macro FWFT_FIFO_MC_ERR_EN).
// Rev    : 1.0 - initial release
// ============================================================================
module fwft_fifo_mc #(
  parameter  int NCH = 4,
  parameter  int FD  = 8,
  parameter  int DW  = 8,
  parameter  int AFT = 6,
  localparam int CW  = $clog2(FD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ffwreq,
  input  logic [NCH*DW-1:0] ffwdata,
  output logic [NCH-1:0]    ffwfull,
  output logic [NCH-1:0]    ffwafull,
  input  logic [NCH-1:0]    ffrreq,
  output logic [NCH*DW-1:0] ffrdata,
  output logic [NCH-1:0]    ffrvld,
  output logic [NCH-1:0]    ffrempty,
  output logic [NCH*CW-1:0] ffvcnt,
  input  logic [NCH-1:0]    ffflush,
  output logic [NCH*2-1:0]  fferr
);

  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [DW-1:0] mem_q [FD];
      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          full;
      logic          vld;
      logic          wr_acc;
      logic          rd_acc;

      always_comb begin
        full     = (cnt_q == CW'(FD));
        vld      = (cnt_q != '0);
        wr_acc   = ffwreq[c] & ~full;
        rd_acc   = ffrreq[c] & vld;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (ffflush[c]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          // Explicit wrap so FD need not be a power of two.
          if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + 1'b1;
          if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + 1'b1;
          cnt_d = cnt_q + CW'(wr_acc) - CW'(rd_acc);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Storage is not reset; validity comes only from the count.
      always_ff @(posedge clk) begin
        if (wr_acc && !ffflush[c]) mem_q[wr_ptr_q] <= ffwdata[c*DW +: DW];
      end

      assign ffrdata[c*DW +: DW]  = mem_q[rd_ptr_q];
      assign ffrvld[c]            = vld;
      assign ffrempty[c]          = ~vld;
      assign ffwfull[c]           = full;
      assign ffwafull[c]          = (cnt_q >= CW'(AFT));
      assign ffvcnt[c*CW +: CW]   = cnt_q;

`ifdef FWFT_FIFO_MC_ERR_EN
      logic [1:0] err_q, err_d;

      always_comb begin
        err_d = err_q;
        if (ffwreq[c] & full) err_d[0] = 1'b1;
        if (ffrreq[c] & ~vld) err_d[1] = 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
      end

      assign fferr[2*c +: 2] = err_q;
`else
      assign fferr[2*c +: 2] = 2'b00;
`endif
    end
  endgenerate

endmodule
`default_nettype wire
